// File: rtl/uart_sys_ctrl_if.sv
// Bus bundle between the UART command controller and its neighbours:
// RX byte stream in, register file and ALU control out, TX FIFO push out.
interface uart_sys_ctrl_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_OUT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]    RX_P_DATA;
    logic                     RX_D_VLD;
    logic [DATA_WIDTH-1:0]    RF_RdData;
    logic                     RF_RdData_VLD;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VLD;
    logic                     FIFO_FULL;
    logic [ADDR_WIDTH-1:0]    RF_Address;
    logic                     RF_WrEn;
    logic                     RF_RdEn;
    logic [DATA_WIDTH-1:0]    RF_WrData;
    logic                     ALU_EN;
    logic [3:0]               ALU_FUN;
    logic                     CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]    TX_P_DATA;
    logic                     TX_D_VLD;

    // Controller side
    modport master (
        input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        output RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD
    );

    // Environment side (RX sync, register file, ALU, TX FIFO)
    modport slave (
        output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD
    );
endinterface

// File: rtl/uart_sys_ctrl.sv
// UART command controller: decodes write / read / ALU frames from the RX byte
// stream, drives the register file and ALU, and pushes responses into the TX FIFO.
// All outputs are registered; strobes are single-cycle.
module uart_sys_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_OUT_WIDTH = 16
) (
    input logic             CLK,
    input logic             RST,
    uart_sys_ctrl_if.master bus
);

    localparam logic [DATA_WIDTH-1:0] CmdWrite  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CmdRead   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CmdAluOp  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CmdAluNop = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StOpA,
        StOpB, StAluFun, StAluWait, StTxRd, StTxLo, StTxHi
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   alu_hi_q;
    logic [ADDR_WIDTH-1:0]   rf_addr_q;
    logic [DATA_WIDTH-1:0]   rf_wdata_q;
    logic                    rf_wr_en_q;
    logic                    rf_rd_en_q;
    logic                    alu_en_q;
    logic [3:0]              alu_fun_q;
    logic                    clk_gate_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    tx_vld_q;

    // Frame decoder FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            wr_addr_q  <= '0;
            alu_hi_q   <= '0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            alu_en_q   <= 1'b0;
            alu_fun_q  <= '0;
            clk_gate_q <= 1'b0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
        end else begin
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            alu_en_q   <= 1'b0;
            tx_vld_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.RX_D_VLD) begin
                        case (bus.RX_P_DATA)
                            CmdWrite:  state_q <= StWrAddr;
                            CmdRead:   state_q <= StRdAddr;
                            CmdAluOp:  state_q <= StOpA;
                            CmdAluNop: state_q <= StAluFun;
                            default:   state_q <= StIdle;
                        endcase
                    end
                end
                StWrAddr: begin
                    if (bus.RX_D_VLD) begin
                        wr_addr_q <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        state_q   <= StWrData;
                    end
                end
                StWrData: begin
                    if (bus.RX_D_VLD) begin
                        rf_addr_q  <= wr_addr_q;
                        rf_wdata_q <= bus.RX_P_DATA;
                        rf_wr_en_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                StRdAddr: begin
                    if (bus.RX_D_VLD) begin
                        rf_addr_q  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
                        rf_rd_en_q <= 1'b1;
                        state_q    <= StRdWait;
                    end
                end
                StRdWait: begin
                    // Push in the same edge as the capture when the FIFO has room,
                    // otherwise park in StTxRd until it drains.
                    if (bus.RF_RdData_VLD) begin
                        tx_data_q <= bus.RF_RdData;
                        if (!bus.FIFO_FULL) begin
                            tx_vld_q <= 1'b1;
                            state_q  <= StIdle;
                        end else begin
                            state_q  <= StTxRd;
                        end
                    end
                end
                StOpA: begin
                    if (bus.RX_D_VLD) begin
                        rf_addr_q  <= '0;
                        rf_wdata_q <= bus.RX_P_DATA;
                        rf_wr_en_q <= 1'b1;
                        state_q    <= StOpB;
                    end
                end
                StOpB: begin
                    if (bus.RX_D_VLD) begin
                        rf_addr_q  <= ADDR_WIDTH'(1);
                        rf_wdata_q <= bus.RX_P_DATA;
                        rf_wr_en_q <= 1'b1;
                        state_q    <= StAluFun;
                    end
                end
                StAluFun: begin
                    if (bus.RX_D_VLD) begin
                        alu_fun_q  <= bus.RX_P_DATA[3:0];
                        alu_en_q   <= 1'b1;
                        clk_gate_q <= 1'b1;
                        state_q    <= StAluWait;
                    end
                end
                StAluWait: begin
                    if (bus.ALU_OUT_VLD) begin
                        clk_gate_q <= 1'b0;
                        alu_hi_q   <= bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        tx_data_q  <= bus.ALU_OUT[DATA_WIDTH-1:0];
                        if (!bus.FIFO_FULL) begin
                            tx_vld_q <= 1'b1;
                            state_q  <= StTxHi;
                        end else begin
                            state_q  <= StTxLo;
                        end
                    end
                end
                StTxRd: begin
                    if (!bus.FIFO_FULL) begin
                        tx_vld_q <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                StTxLo: begin
                    if (!bus.FIFO_FULL) begin
                        tx_vld_q <= 1'b1;
                        state_q  <= StTxHi;
                    end
                end
                StTxHi: begin
                    if (!bus.FIFO_FULL) begin
                        tx_data_q <= alu_hi_q;
                        tx_vld_q  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.RF_Address  = rf_addr_q;
    assign bus.RF_WrData   = rf_wdata_q;
    assign bus.RF_WrEn     = rf_wr_en_q;
    assign bus.RF_RdEn     = rf_rd_en_q;
    assign bus.ALU_EN      = alu_en_q;
    assign bus.ALU_FUN     = alu_fun_q;
    assign bus.CLK_GATE_EN = clk_gate_q;
    assign bus.TX_P_DATA   = tx_data_q;
    assign bus.TX_D_VLD    = tx_vld_q;

endmodule

// File: doc/uart_sys_ctrl.md
# uart_sys_ctrl

Command controller at the far end of the UART link. It consumes bytes delivered by the UART receiver and decodes four command frames: register write, register read, ALU operation with operands, and ALU operation without operands. It drives the register file and the ALU, then pushes response bytes into the TX-side FIFO that feeds the UART transmitter. It runs in the reference (system) clock domain, between the RX data synchronizer and the TX async FIFO.

## Interface
- DATA_WIDTH, 8, byte width of UART data, register file data and FIFO data
- ADDR_WIDTH, 4, register file address width
- ALU_OUT_WIDTH, 16, ALU result width; must equal 2×DATA_WIDTH
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- RX_P_DATA  in  DATA_WIDTH  received byte, already synchronized into CLK domain
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RF_RdData  in  DATA_WIDTH  register file read data
- RF_RdData_VLD  in  1  one-cycle pulse, RF_RdData valid
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result
- ALU_OUT_VLD  in  1  one-cycle pulse, ALU_OUT valid
- FIFO_FULL  in  1  TX FIFO full; no push permitted while high
- RF_Address  out  ADDR_WIDTH  register file address
- RF_WrEn  out  1  register file write strobe, one cycle
- RF_RdEn  out  1  register file read strobe, one cycle
- RF_WrData  out  DATA_WIDTH  register file write data
- ALU_EN  out  1  ALU start strobe, one cycle
- ALU_FUN  out  4  ALU function code
- CLK_GATE_EN  out  1  enables the ALU clock gate
- TX_P_DATA  out  DATA_WIDTH  byte pushed to TX FIFO
- TX_D_VLD  out  1  FIFO push strobe, one cycle per byte

## Operation
- Command bytes:
  - 0xAA: write; frame is AA, addr, data.
  - 0xBB: read; frame is BB, addr.
  - 0xCC: ALU with operands; frame is CC, A, B, fun.
  - 0xDD: ALU without operands; frame is DD, fun.
- Any other byte received in IDLE is discarded; the FSM stays in IDLE.
- Address bytes use only bits [ADDR_WIDTH-1:0]; the upper bits are ignored. Fun bytes use bits [3:0].
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- Write path: IDLE -AA-> WR_ADDR -addr-> WR_DATA -data-> IDLE. The write strobe is issued with the stored addr.
- Read path: IDLE -BB-> RD_ADDR -addr-> RD_WAIT. RF_RdEn is pulsed on entry to RD_WAIT. On RF_RdData_VLD, the data is captured and the FSM moves to TX_RD. After the push, the FSM returns to IDLE.
- ALU with operands: IDLE -CC-> OP_A -A-> OP_B -B-> ALU_FUN -fun-> ALU_WAIT.
  - A is written to RF address 0.
  - B is written to RF address 1.
- ALU without operands: IDLE -DD-> ALU_FUN. The ALU uses the current contents of RF addresses 0 and 1.
- ALU_WAIT: on ALU_OUT_VLD, the result is captured, then the FSM goes TX_LO -> TX_HI -> IDLE. The low byte is sent first.
- TX_* states: the push occurs only in a cycle where FIFO_FULL=0. Otherwise the FSM waits in the same state with TX_P_DATA held.
- RX_D_VLD received in RD_WAIT, ALU_WAIT or any TX_* state: the byte is dropped, and the FSM is not disturbed.
- CLK_GATE_EN goes to 1 when the fun byte is accepted. It returns to 0 in the cycle after ALU_OUT_VLD. It is 0 in all other states.

## Timing
- Reset values: all outputs 0; FSM in IDLE; captured data registers 0.
- RST asserted mid-frame aborts the frame immediately. No partial strobes are issued, and after release the FSM starts in IDLE.
- All outputs are registered. Every strobe (RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD) is exactly one cycle wide and is asserted in the cycle after the triggering RX_D_VLD or VLD input is sampled.
- RF_Address and RF_WrData are valid in the same cycle as RF_WrEn or RF_RdEn and are held until the next strobe.
- ALU_FUN is valid with ALU_EN and is held until the next ALU_EN.
- Write latency: RF_WrEn is high 1 cycle after the data byte's RX_D_VLD.
- Read latency: RF_RdEn is high 1 cycle after the addr byte's RX_D_VLD. TX_D_VLD is high 1 cycle after RF_RdData_VLD, if the FIFO is not full.
- ALU response: the first TX_D_VLD (low byte) is high 1 cycle after ALU_OUT_VLD. The second TX_D_VLD (high byte) follows no earlier than the next cycle and is gated by FIFO_FULL.
- FIFO_FULL is sampled in the same cycle the push decision is made. FIFO_FULL rising in the same cycle as a pending push blocks that push.
- Back-to-back frames are allowed: a command byte arriving 1 cycle after a frame's final strobe is accepted.

## Test plan
- AA, 05, 3C with FIFO_FULL=0 -> one RF_WrEn pulse with RF_Address=5 and RF_WrData=0x3C; no TX_D_VLD.
- BB, 05; RF returns 0x3C 2 cycles after RF_RdEn -> RF_RdEn pulse with addr 5, then exactly one TX_D_VLD with TX_P_DATA=0x3C.
- CC, 07, 03, 00 (add); ALU returns 0x000A -> RF writes addr0=07 and addr1=03; ALU_EN with ALU_FUN=0; CLK_GATE_EN high until result; TX bytes 0x0A then 0x00.
- DD, 02 with FIFO_FULL=1 for 5 cycles after ALU_OUT_VLD=0x0015 -> no push while full; then 0x15 and 0x00 pushed in order; TX_P_DATA stable while stalled.
- Garbage byte 0x55 in IDLE, and a byte received during RD_WAIT -> ignored; the subsequent AA frame completes correctly.
- RST asserted after AA, 05 (before the data byte) -> all outputs 0, no RF_WrEn; after release, a BB frame works normally.
